// File: rtl/adc_sample_scheduler_if.sv
// adc_sample_scheduler_if
//   Control, ADC-manager and sample-stream signals of the ADC sample scheduler.
//   slave  : the scheduler's view (drives conv_start, the sample stream and flags).
//   master : the environment's view (drives enable, rate_div, ADC byte strobe/data,
//            sample_ready and clear_err).
//   Signals: enable, rate_div[DIV_W], conv_start, new_byte, adc_data[8],
//            sample_data[8], sample_valid, sample_ready, fifo_level[LVL_W],
//            overrun, late, timeout_err, clear_err.
interface adc_sample_scheduler_if #(
   parameter int unsigned DIV_W      = 16,
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic             enable;
   logic [DIV_W-1:0] rate_div;
   logic             conv_start;
   logic             new_byte;
   logic [7:0]       adc_data;
   logic [7:0]       sample_data;
   logic             sample_valid;
   logic             sample_ready;
   logic [LVL_W-1:0] fifo_level;
   logic             overrun;
   logic             late;
   logic             timeout_err;
   logic             clear_err;

   modport slave (
      input  enable, rate_div, new_byte, adc_data, sample_ready, clear_err,
      output conv_start, sample_data, sample_valid, fifo_level, overrun, late, timeout_err
   );

   modport master (
      output enable, rate_div, new_byte, adc_data, sample_ready, clear_err,
      input  conv_start, sample_data, sample_valid, fifo_level, overrun, late, timeout_err
   );
endinterface

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler
//   Issues one conv_start pulse per programmable sample period to the ADC
//   serial-read manager, captures each returned byte into a first-word-fall-through
//   FIFO and presents it on a valid/ready stream. Sticky flags report dropped
//   samples (overrun), period ticks during a conversion (late) and conversions
//   that never answered (timeout_err).
//   Ports: clk, rst (synchronous, active high), bus (adc_sample_scheduler_if.slave).
module adc_sample_scheduler #(
   parameter int unsigned DIV_W          = 16,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2048
) (
   input  logic                    clk,
   input  logic                    rst,
   adc_sample_scheduler_if.slave   bus
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_CONVERT
   } state_t;

   state_t           r_state;
   logic [DIV_W-1:0] r_cnt;
   logic [TMO_W-1:0] r_tmo;
   logic             r_conv_start;
   logic             r_overrun;
   logic             r_late;
   logic             r_timeout;
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wp;
   logic [PTR_W-1:0] r_rp;
   logic [LVL_W-1:0] r_level;

   logic             w_run;
   logic             w_tick;
   logic [DIV_W-1:0] w_reload;
   logic             w_push_req;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_tmo_hit;
   logic             w_late_ev;
   logic             w_ovr_ev;

   // The counter only runs once the FSM has left IDLE, so the first tick lands
   // in the cycle after enable rises, when the FSM is ARMED to take it.
   assign w_run      = bus.enable && (r_state != S_IDLE);
   assign w_tick     = w_run && (r_cnt == '0);
   assign w_reload   = (bus.rate_div < DIV_W'(2)) ? DIV_W'(1) : (bus.rate_div - DIV_W'(1));

   assign w_push_req = (r_state == S_CONVERT) && bus.new_byte;
   assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_pop      = (r_level != '0) && bus.sample_ready;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_ovr_ev   = w_push_req && w_full && !w_pop;
   assign w_tmo_hit  = (r_state == S_CONVERT) && !bus.new_byte &&
                       (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
   assign w_late_ev  = w_tick && (r_state == S_CONVERT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_tmo        <= '0;
         r_conv_start <= 1'b0;
         r_overrun    <= 1'b0;
         r_late       <= 1'b0;
         r_timeout    <= 1'b0;
         r_wp         <= '0;
         r_rp         <= '0;
         r_level      <= '0;
      end else begin
         r_conv_start <= 1'b0;

         if (!bus.enable) begin
            r_cnt <= '0;
         end else if (w_run) begin
            r_cnt <= (r_cnt == '0) ? w_reload : (r_cnt - DIV_W'(1));
         end

         case (r_state)
            S_IDLE: begin
               if (bus.enable) r_state <= S_ARMED;
            end
            S_ARMED: begin
               if (!bus.enable) begin
                  r_state <= S_IDLE;
               end else if (w_tick) begin
                  r_conv_start <= 1'b1;
                  r_tmo        <= '0;
                  r_state      <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               // A tick here is discarded (flagged as late); the conversion runs on.
               if (bus.new_byte || w_tmo_hit) begin
                  r_state <= bus.enable ? S_ARMED : S_IDLE;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Setting events take priority over clear_err.
         r_overrun <= w_ovr_ev  | (r_overrun & ~bus.clear_err);
         r_late    <= w_late_ev | (r_late    & ~bus.clear_err);
         r_timeout <= w_tmo_hit | (r_timeout & ~bus.clear_err);

         if (w_push) r_wp <= r_wp + PTR_W'(1);
         if (w_pop)  r_rp <= r_rp + PTR_W'(1);
         if (w_push && !w_pop) begin
            r_level <= r_level + LVL_W'(1);
         end else if (!w_push && w_pop) begin
            r_level <= r_level - LVL_W'(1);
         end
      end
   end

   // Storage needs no reset: pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push && !rst) r_mem[r_wp] <= bus.adc_data;
   end

   assign bus.conv_start   = r_conv_start;
   assign bus.sample_valid = (r_level != '0);
   assign bus.sample_data  = (r_level != '0) ? r_mem[r_rp] : '0;
   assign bus.fifo_level   = r_level;
   assign bus.overrun      = r_overrun;
   assign bus.late         = r_late;
   assign bus.timeout_err  = r_timeout;
endmodule

// File: doc/adc_sample_scheduler.md
Name: adc_sample_scheduler

Overview:
Sequences the ADC serial-read manager at a programmable sample rate. Issues one conversion-start pulse per sample period and captures each completed byte (NEW_BYTE strobe plus parallel data) into a small first-word-fall-through FIFO. Presents captured samples to the modulator datapath over a valid/ready handshake. Flags overruns, missed periods and conversion timeouts.

Parameters:
DIV_W, 16, width of rate_div.
FIFO_DEPTH, 4, sample FIFO entries; power of two, at least 2.
TIMEOUT_CYCLES, 2048, clk cycles allowed from conv_start to new_byte before abort.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
enable  in  1  run scheduling; low = no new conversions.
rate_div  in  DIV_W  sample period in clk cycles; values 0..1 are treated as 2.
conv_start  out  1  one-cycle pulse to the ADC manager to begin a conversion.
new_byte  in  1  ADC manager NEW_BYTE strobe, one cycle.
adc_data  in  8  ADC manager out_parallel; valid when new_byte=1.
sample_data  out  8  FIFO head.
sample_valid  out  1  FIFO not empty.
sample_ready  in  1  consumer accepts the head.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
overrun  out  1  sticky: a sample was dropped because the FIFO was full.
late  out  1  sticky: a period tick arrived while a conversion was still in progress.
timeout_err  out  1  sticky: a conversion exceeded TIMEOUT_CYCLES.
clear_err  in  1  clears all sticky flags.

Behaviour:
- Reset: state IDLE, period counter = 0, FIFO empty, fifo_level = 0, conv_start = 0, sample_valid = 0, sample_data = 0, all sticky flags = 0.
- Period counter runs only while enable = 1. At 0 it generates a tick and reloads with max(rate_div,2)-1. rate_div is sampled only at reload. While enable = 0 the counter is held at 0, so the first tick comes one cycle after enable rises.
- FSM:
  - IDLE: enable=1 -> ARMED.
  - ARMED: tick -> register conv_start=1 for exactly one cycle, clear the timeout counter, go to CONVERT. enable=0 -> IDLE.
  - CONVERT: new_byte -> push adc_data, go to ARMED (or IDLE if enable=0). Timeout counter reaches TIMEOUT_CYCLES-1 with no new_byte -> set timeout_err, return to ARMED/IDLE, no push. A tick in CONVERT sets late; the tick is discarded, with no queued start.
- Deasserting enable mid-conversion: the conversion still completes or times out. No further conv_start is issued.
- new_byte outside CONVERT is ignored; no push and no flag.
- FIFO is first-word-fall-through: sample_valid = !empty and sample_data = head. Pop when sample_valid && sample_ready.
- Latency: new_byte in cycle n with the FIFO empty -> sample_valid=1 and sample_data=byte in cycle n+1.
- Push with the FIFO full and no pop in the same cycle: the byte is dropped, overrun is set, and FIFO contents are unchanged. Push and pop in the same cycle with the FIFO full: both occur, the level stays FIFO_DEPTH, no overrun.
- Read and write pointers wrap modulo FIFO_DEPTH. fifo_level is the exact occupancy, 0..FIFO_DEPTH.
- clear_err clears the sticky flags next cycle. If a flag-setting event coincides with clear_err, the event wins and the flag is 1.
- rst overrides everything in the cycle it is sampled, including mid-conversion. The FIFO is flushed and an in-flight conv_start pulse is suppressed.

Test Plan:
- Basic cadence: rate_div=100, enable=1, model returns new_byte 40 cycles after each conv_start with data 0x11,0x22,0x33 -> conv_start pulses exactly 100 cycles apart; sample_data sequence 0x11,0x22,0x33; each sample_valid appears 1 cycle after its new_byte; flags stay 0.
- Overrun: FIFO_DEPTH=4, sample_ready=0, 6 conversions -> fifo_level saturates at 4, holding samples 1-4; overrun=1 after the 5th byte; samples 5-6 dropped. Then ready=1 -> exactly 4 pops, in order.
- Full with simultaneous pop: FIFO full and sample_ready=1 on the same cycle as new_byte -> level stays 4, the new byte is at the tail, overrun remains 0.
- Timeout and late: TIMEOUT_CYCLES=50, rate_div=30, model never answers -> late=1 at the first tick inside CONVERT; timeout_err=1 at 50 cycles after conv_start; next conv_start on the following tick. clear_err -> both flags 0.
- Clamping and enable: rate_div=0 -> conv_start every 2 cycles with immediate-response model. enable dropped during CONVERT -> the pending byte is still pushed and no further conv_start is issued.
- Reset mid-operation: rst asserted while in CONVERT with 3 samples queued -> next cycle fifo_level=0, sample_valid=0, conv_start=0, flags 0. A new_byte arriving after reset, before re-enable, is ignored.
